quick_spi: RTL and testbench

QUICK_SPI -- requirements
Module: quick_spi

---
 rtl/quick_spi.sv | 138 +++++++++++++
 tb/tb_quick_spi.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/quick_spi.sv
// Half-duplex SPI master: shifts out a write word, then shifts in a read word, MSB first.
// sclk runs at clk/2; every output is registered.
module quick_spi #(
  parameter int unsigned OUTGOING_DATA_WIDTH = 16,
  parameter int unsigned INCOMING_DATA_WIDTH = 8,
  parameter int unsigned NUMBER_OF_SLAVES    = 2,
  parameter int unsigned SLAVE_INDEX         = 0,
  parameter logic        CPOL                = 1'b0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           enable,
  output logic                           busy,
  input  logic [OUTGOING_DATA_WIDTH-1:0] outgoing_data,
  output logic [INCOMING_DATA_WIDTH-1:0] incoming_data,
  output logic                           mosi,
  input  logic                           miso,
  output logic                           sclk,
  output logic [NUMBER_OF_SLAVES-1:0]    ss_n
);

  localparam int unsigned OW = OUTGOING_DATA_WIDTH;
  localparam int unsigned IW = INCOMING_DATA_WIDTH;
  localparam int unsigned NS = NUMBER_OF_SLAVES;
  localparam int unsigned CW = $clog2(((OW > IW) ? OW : IW) + 1);
  localparam logic [NS-1:0] SS_IDLE = {NS{1'b1}};
  localparam logic [NS-1:0] SS_SEL  = ~(NS'(1) << SLAVE_INDEX);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t        state, state_nxt;
  logic          phase, phase_nxt;       // 1 once the leading edge of the current bit has happened
  logic [CW-1:0] bit_cnt, bit_cnt_nxt;
  logic [OW-1:0] tx_sr, tx_sr_nxt, tx_shift;
  logic [IW-1:0] rx_sr, rx_sr_nxt;
  logic          busy_nxt, sclk_nxt, mosi_nxt;
  logic [NS-1:0] ss_n_nxt;
  logic [IW-1:0] incoming_data_nxt;

  assign tx_shift = tx_sr << 1;

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      phase         <= 1'b0;
      bit_cnt       <= '0;
      tx_sr         <= '0;
      rx_sr         <= '0;
      busy          <= 1'b0;
      sclk          <= CPOL;
      mosi          <= 1'b0;
      ss_n          <= SS_IDLE;
      incoming_data <= '0;
    end else begin
      state         <= state_nxt;
      phase         <= phase_nxt;
      bit_cnt       <= bit_cnt_nxt;
      tx_sr         <= tx_sr_nxt;
      rx_sr         <= rx_sr_nxt;
      busy          <= busy_nxt;
      sclk          <= sclk_nxt;
      mosi          <= mosi_nxt;
      ss_n          <= ss_n_nxt;
      incoming_data <= incoming_data_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt         = state;
    phase_nxt         = phase;
    bit_cnt_nxt       = bit_cnt;
    tx_sr_nxt         = tx_sr;
    rx_sr_nxt         = rx_sr;
    busy_nxt          = busy;
    sclk_nxt          = sclk;
    mosi_nxt          = mosi;
    ss_n_nxt          = ss_n;
    incoming_data_nxt = incoming_data;

    unique case (state)
      IDLE: begin
        if (enable) begin
          state_nxt   = WRITE;
          phase_nxt   = 1'b0;
          bit_cnt_nxt = '0;
          tx_sr_nxt   = outgoing_data;
          mosi_nxt    = outgoing_data[OW-1];
          busy_nxt    = 1'b1;
          ss_n_nxt    = SS_SEL;
        end
      end

      WRITE: begin
        if (!phase) begin
          sclk_nxt  = ~CPOL;
          phase_nxt = 1'b1;
        end else begin
          sclk_nxt  = CPOL;
          phase_nxt = 1'b0;
          if (bit_cnt == CW'(OW - 1)) begin
            state_nxt   = READ;
            mosi_nxt    = 1'b0;
            bit_cnt_nxt = '0;
          end else begin
            tx_sr_nxt   = tx_shift;
            mosi_nxt    = tx_shift[OW-1];
            bit_cnt_nxt = bit_cnt + CW'(1);
          end
        end
      end

      READ: begin
        // The leading slot after the last read bit is the completion edge
        if (!phase) begin
          if (bit_cnt == CW'(IW)) begin
            state_nxt         = IDLE;
            busy_nxt          = 1'b0;
            ss_n_nxt          = SS_IDLE;
            incoming_data_nxt = rx_sr;
          end else begin
            sclk_nxt  = ~CPOL;
            phase_nxt = 1'b1;
            rx_sr_nxt = (rx_sr << 1) | IW'(miso);
          end
        end else begin
          sclk_nxt    = CPOL;
          phase_nxt   = 1'b0;
          bit_cnt_nxt = bit_cnt + CW'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_quick_spi.sv
// Bench for quick_spi: transaction-level model checked every cycle against CPOL=0 and CPOL=1 instances.
module tb_quick_spi;

  localparam int OW = 16;
  localparam int IW = 8;
  localparam int NS = 2;
  localparam int SI = 0;
  localparam int N  = OW + IW;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic scramble = 1'b0;
  logic [OW-1:0] out_val = 16'h5A5A;
  logic [OW-1:0] rnd_word = '0;
  logic [OW-1:0] outgoing_data;
  int miso_mode = 0;
  logic miso_val = 1'b1;
  logic rnd_bit = 1'b0;
  logic pat_bit = 1'b0;
  logic [IW-1:0] pat = 8'hA5;
  logic miso;

  logic busy0, busy1, mosi0, mosi1, sclk0, sclk1;
  logic [IW-1:0] in0, in1;
  logic [NS-1:0] ss0, ss1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign outgoing_data = scramble ? rnd_word : out_val;
  assign miso = (miso_mode == 0) ? miso_val : (miso_mode == 1) ? rnd_bit : pat_bit;

  quick_spi #(.OUTGOING_DATA_WIDTH(OW), .INCOMING_DATA_WIDTH(IW), .NUMBER_OF_SLAVES(NS),
              .SLAVE_INDEX(SI), .CPOL(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .busy(busy0), .outgoing_data(outgoing_data),
    .incoming_data(in0), .mosi(mosi0), .miso(miso), .sclk(sclk0), .ss_n(ss0));

  quick_spi #(.OUTGOING_DATA_WIDTH(OW), .INCOMING_DATA_WIDTH(IW), .NUMBER_OF_SLAVES(NS),
              .SLAVE_INDEX(SI), .CPOL(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .busy(busy1), .outgoing_data(outgoing_data),
    .incoming_data(in1), .mosi(mosi1), .miso(miso), .sclk(sclk1), .ss_n(ss1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: m_t counts clk edges since the start edge of the current transaction
  logic          m_act = 1'b0;
  int            m_t = 0;
  logic [OW-1:0] m_word = '0;
  logic [IW-1:0] m_rx = '0;
  logic [IW-1:0] m_in = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_act = 1'b0;
      m_t   = 0;
      m_rx  = '0;
      m_in  = '0;
    end else if (!m_act) begin
      if (enable) begin
        m_act  = 1'b1;
        m_t    = 0;
        m_word = outgoing_data;
      end
    end else begin
      m_t++;
      if ((m_t % 2 == 1) && (m_t / 2 >= OW) && (m_t / 2 < N))
        m_rx[IW-1-(m_t/2-OW)] = miso;
      if (m_t == 2 * N + 1) begin
        m_act = 1'b0;
        m_in  = m_rx;
      end
    end
  end

  function automatic logic exp_sclk(input logic cpol);
    return m_act ? (cpol ^ (m_t % 2 == 1)) : cpol;
  endfunction

  function automatic logic exp_mosi();
    if (m_act && (m_t / 2 < OW)) return m_word[OW-1-m_t/2];
    return 1'b0;
  endfunction

  function automatic logic [NS-1:0] exp_ss();
    logic [NS-1:0] sel;
    sel = ~(NS'(1) << SI);
    return m_act ? sel : {NS{1'b1}};
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("busy0", 32'(busy0), 32'(m_act));
    chk("busy1", 32'(busy1), 32'(m_act));
    chk("sclk0", 32'(sclk0), 32'(exp_sclk(1'b0)));
    chk("sclk1", 32'(sclk1), 32'(exp_sclk(1'b1)));
    chk("mosi0", 32'(mosi0), 32'(exp_mosi()));
    chk("mosi1", 32'(mosi1), 32'(exp_mosi()));
    chk("ss_n0", 32'(ss0), 32'(exp_ss()));
    chk("ss_n1", 32'(ss1), 32'(exp_ss()));
    chk("incoming0", 32'(in0), 32'(m_in));
    chk("incoming1", 32'(in1), 32'(m_in));
  end

  // Random sources and the miso pattern (next bit presented after each trailing edge)
  always @(negedge clk) begin
    rnd_word = OW'($urandom);
    rnd_bit  = 1'($urandom);
    if (m_act && (m_t % 2 == 0) && (m_t / 2 >= OW) && (m_t / 2 < N))
      pat_bit = pat[IW-1-(m_t/2-OW)];
  end

  // Observation of leading edges: pulse counts and mosi at each leading edge
  int busy_cnt = 0;
  int pulses0 = 0;
  int pulses1 = 0;
  logic [31:0] seq0 = '0;
  logic [31:0] seq1 = '0;
  logic prev0 = 1'b0;
  logic prev1 = 1'b1;

  always @(negedge clk) begin
    if (busy0) busy_cnt++;
    if (busy0 && sclk0 && !prev0) begin
      pulses0++;
      seq0 = {seq0[30:0], mosi0};
    end
    if (busy1 && !sclk1 && prev1) begin
      pulses1++;
      seq1 = {seq1[30:0], mosi1};
    end
    prev0 = sclk0;
    prev1 = sclk1;
  end

  task automatic wait_busy(input logic val, input int max, output int waited);
    waited = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      #1;
      waited++;
      if (busy0 === val) return;
    end
    chk("wait_busy_timeout", 32'(busy0), 32'(val));
  endtask

  initial begin
    int w, b0, p0, p1, hi;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_ss_n", 32'(ss0), 32'h3);
    chk("rst_sclk1", 32'(sclk1), 32'd1);
    chk("rst_incoming", 32'(in0), 32'd0);
    reset_n = 1'b1;

    // Fixed 5A5A write, miso held high
    b0 = busy_cnt; p0 = pulses0; p1 = pulses1;
    enable = 1'b1;
    wait_busy(1'b1, 10, w);
    enable = 1'b0;
    wait_busy(1'b0, 100, w);
    chk("t1_busy_cycles", 32'(busy_cnt - b0), 32'd49);
    chk("t1_pulses0", 32'(pulses0 - p0), 32'd24);
    chk("t1_pulses1", 32'(pulses1 - p1), 32'd24);
    chk("t1_mosi_seq0", {8'h0, seq0[23:0]}, 32'h005A5A00);
    chk("t1_mosi_seq1", {8'h0, seq1[23:0]}, 32'h005A5A00);
    chk("t1_incoming0", 32'(in0), 32'hFF);
    chk("t1_incoming1", 32'(in1), 32'hFF);

    // A5 read pattern, single-cycle enable pulse
    out_val = OW'($urandom);
    miso_mode = 2;
    enable = 1'b1;
    @(negedge clk);
    #1;
    enable = 1'b0;
    wait_busy(1'b0, 100, w);
    chk("t2_incoming0", 32'(in0), 32'hA5);
    chk("t2_incoming1", 32'(in1), 32'hA5);
    hi = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (busy0) hi++;
    end
    chk("t2_single_txn", 32'(hi), 32'd0);

    // Enable held high, inputs scrambled during transactions
    miso_mode = 1;
    scramble = 1'b1;
    enable = 1'b1;
    wait_busy(1'b1, 10, w);
    for (int k = 0; k < 3; k++) begin
      wait_busy(1'b0, 100, w);
      wait_busy(1'b1, 10, w);
      chk("idle_gap", 32'(w), 32'd1);
    end
    enable = 1'b0;
    wait_busy(1'b0, 100, w);
    scramble = 1'b0;

    // Reset during bit 10 of the write phase
    out_val = OW'($urandom);
    enable = 1'b1;
    wait_busy(1'b1, 10, w);
    enable = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy0), 32'd0);
    chk("mid_rst_ss_n", 32'(ss0), 32'h3);
    chk("mid_rst_sclk0", 32'(sclk0), 32'd0);
    chk("mid_rst_sclk1", 32'(sclk1), 32'd1);
    chk("mid_rst_mosi", 32'(mosi0), 32'd0);
    chk("mid_rst_incoming", 32'(in0), 32'd0);
    @(negedge clk);
    #1;
    reset_n = 1'b1;

    // Random transactions after the reset
    for (int k = 0; k < 3; k++) begin
      out_val = OW'($urandom);
      b0 = busy_cnt;
      enable = 1'b1;
      wait_busy(1'b1, 10, w);
      enable = 1'b0;
      wait_busy(1'b0, 100, w);
      chk("rand_busy_cycles", 32'(busy_cnt - b0), 32'd49);
      chk("rand_mosi_seq0", {8'h0, seq0[23:0]}, {8'h0, out_val, 8'h00});
    end

    repeat (3) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
